float_acc_seq: RTL and testbench

- Accumulation sequencer that sits directly downstream of the N_MAC product stage and wraps the 3-stage float adder in a feedback loop.
- Accepts a stream of single-precision terms on a valid/ready handshake.
- Issues each term to the adder together with the running sum and captures the adder result after its fixed latency.
- On the term flagged last, emits the total on an output valid/ready handshake and clears the sum for the next vector.

---
 rtl/float_acc_seq.sv | 105 ++++++++++
 tb/tb_float_acc_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/float_acc_seq.sv
// Accumulation sequencer: feeds terms and the running sum to an external
// fixed-latency float adder and emits the total when the last term lands.
module float_acc_seq #(
  parameter int unsigned E_BIT   = 8,
  parameter int unsigned F_BIT   = 23,
  parameter int unsigned ADD_LAT = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1+E_BIT+F_BIT-1:0]   in_data,
  input  logic                       in_last,
  output logic [1+E_BIT+F_BIT-1:0]   add_a,
  output logic [1+E_BIT+F_BIT-1:0]   add_b,
  input  logic [1+E_BIT+F_BIT-1:0]   adder_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1+E_BIT+F_BIT-1:0]   out_data,
  output logic [CNT_W-1:0]           out_cnt,
  output logic                       out_ovf
);

  localparam int unsigned W      = 1 + E_BIT + F_BIT;
  localparam int unsigned WAIT_W = $clog2(ADD_LAT + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state;
  logic [W-1:0]        acc;
  logic [CNT_W-1:0]    cnt;
  logic                ovf;
  logic                last_q;
  logic [WAIT_W-1:0]   wait_cnt;

  logic                exp_ones;
  logic [CNT_W-1:0]    cnt_inc;

  assign in_ready = (state == S_IDLE) && !rst;
  assign exp_ones = &adder_out[F_BIT +: E_BIT];
  assign cnt_inc  = (&cnt) ? cnt : cnt + CNT_W'(1);

  // Issue / wait-for-adder / hold-total sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      last_q    <= 1'b0;
      wait_cnt  <= '0;
      add_a     <= '0;
      add_b     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            add_a    <= acc;
            add_b    <= in_data;
            last_q   <= in_last;
            cnt      <= cnt_inc;
            wait_cnt <= WAIT_W'(ADD_LAT);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end else if (last_q) begin
            // Publish the total and start the next vector from +0.0
            out_data  <= adder_out;
            out_cnt   <= cnt;
            out_ovf   <= ovf | exp_ones;
            out_valid <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            state     <= S_DONE;
          end else begin
            acc   <= adder_out;
            ovf   <= ovf | exp_ones;
            state <= S_IDLE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_acc_seq.sv
// Directed bench for float_acc_seq with a pipelined behavioural float adder
// and a scoreboard of expected totals.
module tb_float_acc_seq;

  localparam int unsigned ADD_LAT = 3;
  localparam int unsigned CNT_W   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              in_last;
  logic [31:0]       add_a;
  logic [31:0]       add_b;
  logic [31:0]       adder_out;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [CNT_W-1:0]  out_cnt;
  logic              out_ovf;

  typedef struct packed {
    logic [31:0]      data;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  float_acc_seq #(.E_BIT(8), .F_BIT(23), .ADD_LAT(ADD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .add_a(add_a), .add_b(add_b), .adder_out(adder_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_cnt(out_cnt), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single precision <-> real for normals and zero; overflow saturates to inf
  function automatic real f2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:0] == 31'd0) return 0.0;
    d = {b[31], 11'(int'(b[30:23]) + 896), b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    return {d[63], 8'(e), d[51:29]};
  endfunction

  // Behavioural adder with ADD_LAT register stages
  logic [31:0] pipe [ADD_LAT];
  always @(posedge clk) begin
    pipe[0] <= r2f(f2r(add_a) + f2r(add_b));
    for (int i = 1; i < ADD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign adder_out = pipe[ADD_LAT-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l, output int ac);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    ac       = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input int c, input logic o);
    exp_t e;
    e.data = d;
    e.cnt  = CNT_W'(c);
    e.ovf  = o;
    sb.push_back(e);
  endtask

  // Wait for a total with out_ready high and compare against the scoreboard
  task automatic get_total(input string tag, output int seen);
    exp_t e;
    int   n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    seen = cyc;
    if (!out_valid) check({tag, "_timeout"}, 64'(out_valid), 64'd1);
    else if (sb.size() == 0) check({tag, "_unexpected"}, 64'(out_valid), 64'd0);
    else begin
      e = sb.pop_front();
      check({tag, "_data"}, 64'(out_data), 64'(e.data));
      check({tag, "_cnt"},  64'(out_cnt),  64'(e.cnt));
      check({tag, "_ovf"},  64'(out_ovf),  64'(e.ovf));
    end
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),  64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_data"},  64'(out_data),  64'd0);
    check({tag, "_out_cnt"},   64'(out_cnt),   64'd0);
    check({tag, "_out_ovf"},   64'(out_ovf),   64'd0);
    check({tag, "_add_a"},     64'(add_a),     64'd0);
    check({tag, "_add_b"},     64'(add_b),     64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, c3, seen;
    logic [31:0] held;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    #1;
    check("ready_after_reset", 64'(in_ready), 64'd1);

    // 1.0 + 2.0 + 3.0 with latency and spacing checks
    send(32'h3F800000, 1'b0, c1);
    send(32'h40000000, 1'b0, c2);
    push(32'h40C00000, 3, 1'b0);
    send(32'h40400000, 1'b1, c3);
    check("accept_spacing", 64'(c2 - c1), 64'(ADD_LAT + 2));
    get_total("vec123", seen);
    check("total_latency", 64'(seen - c3), 64'(ADD_LAT + 1));

    // Single term under backpressure
    out_ready = 1'b0;
    push(32'h40A00000, 1, 1'b0);
    send(32'h40A00000, 1'b1, c1);
    begin
      exp_t e;
      int   n = 0;
      while (!out_valid && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      check("single_valid", 64'(out_valid), 64'd1);
      e = sb.pop_front();
      check("single_data", 64'(out_data), 64'(e.data));
      check("single_cnt",  64'(out_cnt),  64'(e.cnt));
      check("single_ovf",  64'(out_ovf),  64'(e.ovf));
      held     = out_data;
      in_valid = 1'b1;
      in_data  = 32'h41000000;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        check("bp_valid_hold", 64'(out_valid), 64'd1);
        check("bp_data_hold",  64'(out_data),  64'(held));
        check("bp_ready_low",  64'(in_ready),  64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_valid_drop", 64'(out_valid), 64'd0);
      check("bp_ready_rise", 64'(in_ready),  64'd1);
    end

    // Cancellation; the first issue must see a cleared sum
    send(32'h3F800000, 1'b0, c1);
    check("acc_cleared", 64'(add_a), 64'd0);
    push(32'h00000000, 2, 1'b0);
    send(32'hBF800000, 1'b1, c2);
    get_total("cancel", seen);

    // Overflow then a clean vector
    send(32'h7F000000, 1'b0, c1);
    push(32'h7F800000, 2, 1'b1);
    send(32'h7F000000, 1'b1, c2);
    get_total("overflow", seen);
    push(32'h3F800000, 1, 1'b0);
    send(32'h3F800000, 1'b1, c1);
    get_total("after_ovf", seen);

    // Reset in the middle of a 3-term vector
    send(32'h3F800000, 1'b0, c1);
    send(32'h40000000, 1'b0, c2);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_ready", 64'(in_ready), 64'd1);
    push(32'h40000000, 1, 1'b0);
    send(32'h40000000, 1'b1, c1);
    get_total("post_rst", seen);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
